// File: rtl/ab_pattern_driver.sv
// A/B pattern driver and C/D response checker for two-input/two-output lab blocks.
// Latency: first pattern 1 cycle after start; done rises 4*HOLD cycles after start is accepted.
// Backpressure: none; start is ignored while busy. Optional macro AB_DRV_LOOP_EN repeats sweeps while start is held.
module ab_pattern_driver #(
  parameter int         HOLD      = 4,
  parameter logic [7:0] EXP_TABLE = 8'b10_01_01_00,
  parameter int         ERRW      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            A,
  output logic            B,
  input  logic            C,
  input  logic            D,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [1:0]      fail_idx,
  output logic [1:0]      fail_cd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef AB_DRV_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  // The sample edge is the one where the hold counter already reads HOLD-1.
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [7:0]      cnt, cnt_n;
  logic            a_n, b_n, busy_n, done_n, pass_n;
  logic [ERRW-1:0] err_n;
  logic [1:0]      fidx_n, fcd_n;
  logic [1:0]      cd, exp_cd;

  assign cd     = {C, D};
  assign exp_cd = EXP_TABLE[{idx, 1'b0} +: 2];

  // State and all registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= 2'd0;
      fail_cd   <= 2'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      A         <= a_n;
      B         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_idx  <= fidx_n;
      fail_cd   <= fcd_n;
    end
  end

  // Next-state, pattern sequencing and response checking.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    a_n     = A;
    b_n     = B;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_count;
    fidx_n  = fail_idx;
    fcd_n   = fail_cd;

    unique case (state)
      IDLE, DONE: begin
        a_n = 1'b0;
        b_n = 1'b0;
        if (start) begin
          state_n = DRIVE;
          idx_n   = 2'd0;
          cnt_n   = 8'd0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          // In loop mode pass tracks the live error count, which starts clean.
          pass_n  = LOOP_EN;
          err_n   = '0;
          fidx_n  = 2'd0;
          fcd_n   = 2'd0;
        end
      end

      DRIVE: begin
        cnt_n = cnt + 8'd1;
        if (cnt == HOLD_LAST) begin
          if (cd != exp_cd) begin
            if (err_count != ERR_MAX) err_n = err_count + ERRW'(1);
            // Only the first mismatch of a run is recorded.
            if (err_count == '0) begin
              fidx_n = idx;
              fcd_n  = cd;
            end
          end
          if (idx != 2'd3) begin
            idx_n      = idx + 2'd1;
            cnt_n      = 8'd0;
            {a_n, b_n} = idx + 2'd1;
          end else if (LOOP_EN && start) begin
            idx_n      = 2'd0;
            cnt_n      = 8'd0;
            {a_n, b_n} = 2'b00;
          end else begin
            state_n = DONE;
            cnt_n   = 8'd0;
            a_n     = 1'b0;
            b_n     = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end
        end
        if (LOOP_EN && (state_n == DRIVE)) pass_n = (err_n == '0);
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
